// File: rtl/axi_gp_regs_slave.sv
// axi_gp_regs_slave
//   AXI3 slave that exposes sixteen 32-bit registers in one 64-byte window
//   starting at BASE_ADDR. Registers 0..14 are read/write. Register 15 is
//   read-only and returns stat_in; writes to it are accepted and discarded.
//   The read and write paths are independent state machines. Each beat is
//   treated as one 32-bit word, whatever AxSIZE says. FIXED bursts repeat the
//   same address. INCR and WRAP bursts both step the address by 4 per beat.
//
// Optional feature (compile-time macro AXI_REGS_SLVERR_EN):
//   defined   - beats outside the 64-byte window are dropped on write and
//               return 0 on read. They give SLVERR, per beat on R and per
//               burst on B.
//   undefined - upper address bits are ignored, so A[5:2] always selects the
//               register, and every response is OKAY.
//
// Ports
//   ACLK, ARESETN            clock (rising edge), async active-low reset
//   AR*/R*                   read address / read data channels
//   AW*/W*/B*                write address / write data / write response
//   *LOCK/*CACHE/*PROT/*QOS  accepted and ignored, as are WID and WLAST
//   cfg_out                  live value of register 0
//   stat_in                  value returned when register 15 is read

module axi_gp_regs_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        ACLK,
    input  logic        ARESETN,

    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    input  logic [11:0] ARID,
    input  logic [3:0]  ARLEN,
    input  logic [1:0]  ARBURST,
    input  logic [1:0]  ARSIZE,
    input  logic [1:0]  ARLOCK,
    input  logic [3:0]  ARCACHE,
    input  logic [2:0]  ARPROT,
    input  logic [3:0]  ARQOS,

    output logic [31:0] RDATA,
    output logic        RVALID,
    input  logic        RREADY,
    output logic [11:0] RID,
    output logic        RLAST,
    output logic [1:0]  RRESP,

    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [11:0] AWID,
    input  logic [3:0]  AWLEN,
    input  logic [1:0]  AWBURST,
    input  logic [1:0]  AWSIZE,
    input  logic [1:0]  AWLOCK,
    input  logic [3:0]  AWCACHE,
    input  logic [2:0]  AWPROT,
    input  logic [3:0]  AWQOS,

    input  logic [31:0] WDATA,
    input  logic        WVALID,
    output logic        WREADY,
    input  logic [11:0] WID,
    input  logic        WLAST,
    input  logic [3:0]  WSTRB,

    output logic        BVALID,
    input  logic        BREADY,
    output logic [11:0] BID,
    output logic [1:0]  BRESP,

    output logic [31:0] cfg_out,
    input  logic [31:0] stat_in
);

`ifdef AXI_REGS_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    // Without the error feature every address decodes. BASE_ADDR is 64-byte
    // aligned, so (A - BASE_ADDR)[5:2] is the same as A[5:2].
    function automatic logic addr_ok(input logic [31:6] a_hi);
        return !SLVERR_EN || (a_hi == BASE_ADDR[31:6]);
    endfunction

    // These inputs are accepted and have no effect. WLAST is not used because
    // the beat counter marks the end of a write burst.
    logic unused_inputs;
    assign unused_inputs = ^{ARSIZE, AWSIZE, ARLOCK, AWLOCK, ARCACHE, AWCACHE,
                             ARPROT, AWPROT, ARQOS, AWQOS, WID, WLAST,
                             ARADDR[1:0], AWADDR[1:0]};

    // ---------------------------------------------------------------- state
    logic [31:0] regs_q [15];
    logic [31:0] regs_d [15];

    w_state_e    w_state_q, w_state_d;
    logic [31:2] aw_addr_q, aw_addr_d;
    logic [3:0]  w_cnt_q, w_cnt_d;
    logic        w_fixed_q, w_fixed_d;
    logic        w_err_q, w_err_d;
    logic [11:0] bid_q, bid_d;

    r_state_e    r_state_q, r_state_d;
    logic [31:2] ar_addr_q, ar_addr_d;
    logic [3:0]  r_cnt_q, r_cnt_d;
    logic        r_fixed_q, r_fixed_d;
    logic [11:0] rid_q, rid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;

    logic        r_launch;
    logic [31:2] r_launch_addr;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < 15; i++) regs_q[i] <= '0;
            w_state_q <= W_IDLE;
            aw_addr_q <= '0;
            w_cnt_q   <= '0;
            w_fixed_q <= 1'b0;
            w_err_q   <= 1'b0;
            bid_q     <= '0;
            r_state_q <= R_IDLE;
            ar_addr_q <= '0;
            r_cnt_q   <= '0;
            r_fixed_q <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            w_state_q <= w_state_d;
            aw_addr_q <= aw_addr_d;
            w_cnt_q   <= w_cnt_d;
            w_fixed_q <= w_fixed_d;
            w_err_q   <= w_err_d;
            bid_q     <= bid_d;
            r_state_q <= r_state_d;
            ar_addr_q <= ar_addr_d;
            r_cnt_q   <= r_cnt_d;
            r_fixed_q <= r_fixed_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
        end
    end

    // ------------------------------------------------- write next state
    // w_cnt_q is the number of beats still to come after the current one.
    always_comb begin
        w_state_d = w_state_q;
        aw_addr_d = aw_addr_q;
        w_cnt_d   = w_cnt_q;
        w_fixed_d = w_fixed_q;
        w_err_d   = w_err_q;
        bid_d     = bid_q;
        regs_d    = regs_q;
        case (w_state_q)
            W_IDLE: begin
                if (AWVALID) begin
                    aw_addr_d = AWADDR[31:2];
                    bid_d     = AWID;
                    w_cnt_d   = AWLEN;
                    w_fixed_d = (AWBURST == BURST_FIXED);
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID) begin
                    if (addr_ok(aw_addr_q[31:6])) begin
                        // The loop stops at 14, so a write to register 15
                        // matches no entry and is dropped.
                        for (int i = 0; i < 15; i++) begin
                            if (aw_addr_q[5:2] == 4'(i)) begin
                                for (int b = 0; b < 4; b++) begin
                                    if (WSTRB[b]) regs_d[i][8*b +: 8] = WDATA[8*b +: 8];
                                end
                            end
                        end
                    end else begin
                        w_err_d = 1'b1;
                    end
                    if (!w_fixed_q) aw_addr_d = aw_addr_q + 30'd1;
                    if (w_cnt_q == 4'd0) w_state_d = W_RESP;
                    else                 w_cnt_d   = w_cnt_q - 4'd1;
                end
            end
            W_RESP: begin
                if (BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ---------------------------------------------------- write outputs
    always_comb begin
        AWREADY = ARESETN && (w_state_q == W_IDLE);
        WREADY  = (w_state_q == W_DATA);
        BVALID  = (w_state_q == W_RESP);
        BRESP   = (BVALID && w_err_q) ? RESP_SLVERR : RESP_OKAY;
        BID     = bid_q;
    end

    // -------------------------------------------------- read next state
    // The data for a beat is captured into rdata_q on the edge that launches
    // that beat. A write landing in regs_q on the same edge is not seen until
    // a later beat.
    always_comb begin
        r_state_d     = r_state_q;
        ar_addr_d     = ar_addr_q;
        r_cnt_d       = r_cnt_q;
        r_fixed_d     = r_fixed_q;
        rid_d         = rid_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        rlast_d       = rlast_q;
        r_launch      = 1'b0;
        r_launch_addr = ar_addr_q;
        case (r_state_q)
            R_IDLE: begin
                if (ARVALID) begin
                    r_launch      = 1'b1;
                    r_launch_addr = ARADDR[31:2];
                    rid_d         = ARID;
                    r_cnt_d       = ARLEN;
                    r_fixed_d     = (ARBURST == BURST_FIXED);
                    r_state_d     = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    if (r_cnt_q == 4'd0) begin
                        r_state_d = R_IDLE;
                        rlast_d   = 1'b0;
                    end else begin
                        r_launch      = 1'b1;
                        r_launch_addr = r_fixed_q ? ar_addr_q : ar_addr_q + 30'd1;
                        r_cnt_d       = r_cnt_q - 4'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        if (r_launch) begin
            ar_addr_d = r_launch_addr;
            rlast_d   = (r_cnt_d == 4'd0);
            rdata_d   = '0;
            rresp_d   = RESP_SLVERR;
            if (addr_ok(r_launch_addr[31:6])) begin
                rresp_d = RESP_OKAY;
                if (r_launch_addr[5:2] == 4'd15) rdata_d = stat_in;
                for (int i = 0; i < 15; i++) begin
                    if (r_launch_addr[5:2] == 4'(i)) rdata_d = regs_q[i];
                end
            end
        end
    end

    // ----------------------------------------------------- read outputs
    always_comb begin
        ARREADY = ARESETN && (r_state_q == R_IDLE);
        RVALID  = (r_state_q == R_DATA);
        RDATA   = rdata_q;
        RRESP   = rresp_q;
        RID     = rid_q;
        RLAST   = rlast_q;
        cfg_out = regs_q[0];
    end

endmodule

// File: tb/tb_axi_gp_regs_slave.sv
module tb_axi_gp_regs_slave;

    localparam logic [31:0] BASE = 32'h0;
`ifdef AXI_REGS_SLVERR_EN
    localparam bit SLVERR = 1'b1;
`else
    localparam bit SLVERR = 1'b0;
`endif
    localparam int TMO = 64;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [11:0] ARID = '0;
    logic [3:0]  ARLEN = '0;
    logic [1:0]  ARBURST = '0;
    logic [1:0]  ARSIZE = 2'd2;
    logic [1:0]  ARLOCK = '0;
    logic [3:0]  ARCACHE = '0;
    logic [2:0]  ARPROT = '0;
    logic [3:0]  ARQOS = '0;
    logic [31:0] RDATA;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic [11:0] RID;
    logic        RLAST;
    logic [1:0]  RRESP;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [11:0] AWID = '0;
    logic [3:0]  AWLEN = '0;
    logic [1:0]  AWBURST = '0;
    logic [1:0]  AWSIZE = 2'd2;
    logic [1:0]  AWLOCK = '0;
    logic [3:0]  AWCACHE = '0;
    logic [2:0]  AWPROT = '0;
    logic [3:0]  AWQOS = '0;
    logic [31:0] WDATA = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [11:0] WID = '0;
    logic        WLAST = 1'b0;
    logic [3:0]  WSTRB = '0;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [11:0] BID;
    logic [1:0]  BRESP;
    logic [31:0] cfg_out;
    logic [31:0] stat_in = '0;

    always #5 ACLK = ~ACLK;

    axi_gp_regs_slave #(.BASE_ADDR(BASE)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID),
        .ARLEN(ARLEN), .ARBURST(ARBURST), .ARSIZE(ARSIZE), .ARLOCK(ARLOCK),
        .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS),
        .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY), .RID(RID),
        .RLAST(RLAST), .RRESP(RRESP),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID),
        .AWLEN(AWLEN), .AWBURST(AWBURST), .AWSIZE(AWSIZE), .AWLOCK(AWLOCK),
        .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWQOS(AWQOS),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY), .WID(WID),
        .WLAST(WLAST), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
        .cfg_out(cfg_out), .stat_in(stat_in)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: a plain register array indexed by word offset from BASE.
    logic [31:0] mdl [16];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        if (!SLVERR) return 1'b1;
        return (a - BASE) < 32'd64;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(((a - BASE) >> 2) % 32'd16);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (!in_rng(a)) return 32'h0;
        if (idx_of(a) == 15) return stat_in;
        return mdl[idx_of(a)];
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int b);
        return (burst == 2'b00) ? a : a + 32'(4 * b);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, inout logic [1:0] resp);
        if (!in_rng(a)) begin
            resp = 2'b10;
        end else if (idx_of(a) != 15) begin
            for (int k = 0; k < 4; k++) if (s[k]) mdl[idx_of(a)][8*k +: 8] = d[8*k +: 8];
        end
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [11:0] id, input logic [3:0] len, input logic [1:0] burst);
        int n;
        AWADDR = addr; AWID = id; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        while (AWREADY !== 1'b1 && n < TMO) begin @(negedge ACLK); n++; end
        chk("aw_handshake", 64'(n < TMO), 64'd1);
        @(negedge ACLK);
        AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s, input bit last);
        int n;
        WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
        n = 0;
        while (WREADY !== 1'b1 && n < TMO) begin @(negedge ACLK); n++; end
        chk("w_handshake", 64'(n < TMO), 64'd1);
        @(negedge ACLK);
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [11:0] id, input logic [3:0] len, input logic [1:0] burst, input int bdelay);
        logic [1:0] exp_resp;
        logic [14:0] snap;
        int n;
        exp_resp = 2'b00;
        aw_send(addr, id, len, burst);
        for (int b = 0; b <= int'(len); b++) begin
            w_send(wd[b], ws[b], b == int'(len));
            model_write(beat_addr(addr, burst, b), wd[b], ws[b], exp_resp);
        end
        n = 0;
        while (BVALID !== 1'b1 && n < TMO) begin @(negedge ACLK); n++; end
        chk("b_valid", 64'(n < TMO), 64'd1);
        chk("b_resp", 64'(BRESP), 64'(exp_resp));
        chk("b_id", 64'(BID), 64'(id));
        snap = {BVALID, BRESP, BID};
        repeat (bdelay) begin
            @(negedge ACLK);
            chk("b_hold", 64'({BVALID, BRESP, BID}), 64'(snap));
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("b_done", 64'(BVALID), 64'd0);
        chk("cfg_out", 64'(cfg_out), 64'(mdl[0]));
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [11:0] id, input logic [3:0] len, input logic [1:0] burst, input int stall_beat, input int stall_len);
        logic [31:0] a;
        logic [46:0] snap;
        int n;
        ARADDR = addr; ARID = id; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        while (ARREADY !== 1'b1 && n < TMO) begin @(negedge ACLK); n++; end
        chk("ar_handshake", 64'(n < TMO), 64'd1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            a = beat_addr(addr, burst, b);
            if (b == 0) begin
                n = 0;
                while (RVALID !== 1'b1 && n < TMO) begin @(negedge ACLK); n++; end
                chk("r_first", 64'(n < TMO), 64'd1);
            end else begin
                chk("r_nobubble", 64'(RVALID), 64'd1);
            end
            if (b == stall_beat) begin
                RREADY = 1'b0;
                snap = {RDATA, RLAST, RRESP, RID};
                repeat (stall_len) begin
                    @(negedge ACLK);
                    chk("r_stall_hold", 64'({RVALID, RDATA, RLAST, RRESP, RID}), 64'({1'b1, snap}));
                end
            end
            RREADY = 1'b1;
            chk("r_data", 64'(RDATA), 64'(exp_rd(a)));
            chk("r_resp", 64'(RRESP), in_rng(a) ? 64'd0 : 64'd2);
            chk("r_id", 64'(RID), 64'(id));
            chk("r_last", 64'(RLAST), 64'(b == int'(len)));
            @(negedge ACLK);
        end
        RREADY = 1'b0;
        chk("r_done", 64'(RVALID), 64'd0);
    endtask

    function automatic logic [33:0] ctrl_outs();
        return {AWREADY, WREADY, ARREADY, BVALID, RVALID, RLAST, BRESP, RRESP, BID, RID};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [3:0]  rl;
        logic [1:0]  rb;
        for (int i = 0; i < 16; i++) mdl[i] = '0;

        repeat (3) @(negedge ACLK);
        chk("rst_ctrl", 64'(ctrl_outs()), 64'd0);
        chk("rst_rdata", 64'(RDATA), 64'd0);
        chk("rst_cfg", 64'(cfg_out), 64'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("post_rst_ready", 64'({AWREADY, ARREADY, WREADY, BVALID, RVALID}), 64'b11000);

        // Partial-strobe write, then single read.
        wd[0] = 32'hdeadbeef; ws[0] = 4'b1011;
        do_write(BASE + 32'h4, 12'h0, 4'd0, 2'b01, 0);
        do_read(BASE + 32'h4, 12'h5, 4'd0, 2'b01, -1, 0);
        chk("strobe_merge", 64'(mdl[1]), 64'h00000000de00beef);

        // INCR write of four beats, INCR read back.
        for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hf; end
        do_write(BASE + 32'h8, 12'h3, 4'd3, 2'b01, 1);
        do_read(BASE + 32'h8, 12'h7, 4'd3, 2'b01, -1, 0);
        chk("cfg_unchanged", 64'(cfg_out), 64'd0);

        // Back-pressure in the middle of a burst, and a FIXED read of register 0.
        do_read(BASE + 32'h8, 12'h8, 4'd3, 2'b01, 1, 5);
        wd[0] = 32'ha5a50f0f; ws[0] = 4'hf;
        do_write(BASE, 12'h1, 4'd0, 2'b00, 2);
        do_read(BASE, 12'h2, 4'd2, 2'b00, 2, 3);

        // Register 15 is read-only and returns stat_in.
        stat_in = 32'hcafe;
        wd[0] = 32'h1234; ws[0] = 4'hf;
        do_write(BASE + 32'h3c, 12'h4, 4'd0, 2'b01, 0);
        do_read(BASE + 32'h3c, 12'h6, 4'd0, 2'b01, -1, 0);

        // Just past the window: SLVERR with the feature, alias of register 0 without it.
        wd[0] = 32'h5555aaaa; ws[0] = 4'hf;
        do_write(BASE + 32'h40, 12'h11, 4'd0, 2'b01, 0);
        do_read(BASE + 32'h40, 12'h12, 4'd0, 2'b01, -1, 0);

        // Randomised bursts against the model.
        for (int t = 0; t < 24; t++) begin
            ra = BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            rl = 4'($urandom_range(0, 15));
            rb = 2'($urandom_range(0, 2));
            for (int b = 0; b < 16; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
            do_write(ra, 12'($urandom), rl, rb, $urandom_range(0, 3));
            stat_in = $urandom;
            ra = BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            rl = 4'($urandom_range(0, 15));
            rb = 2'($urandom_range(0, 2));
            do_read(ra, 12'($urandom), rl, rb, $urandom_range(0, 16), $urandom_range(1, 4));
        end

        // Reset in the middle of a four-beat write.
        for (int i = 0; i < 15; i++) begin wd[0] = 32'hf00d0000 | 32'(i); ws[0] = 4'hf; do_write(BASE + 32'(4 * i), 12'h0, 4'd0, 2'b01, 0); end
        aw_send(BASE, 12'h33, 4'd3, 2'b01);
        w_send(32'h11111111, 4'hf, 1'b0);
        w_send(32'h22222222, 4'hf, 1'b0);
        ARESETN = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        @(negedge ACLK);
        chk("abort_rst_ctrl", 64'(ctrl_outs()), 64'd0);
        chk("abort_rst_cfg", 64'(cfg_out), 64'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("abort_ready", 64'({AWREADY, ARREADY}), 64'b11);
        repeat (4) begin
            @(negedge ACLK);
            chk("abort_no_b", 64'(BVALID), 64'd0);
        end
        stat_in = 32'h0badf00d;
        do_read(BASE, 12'h9, 4'd15, 2'b01, -1, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/axi_gp_regs_slave.md
AXI_GP_REGS_SLAVE -- requirements
Module: axi_gp_regs_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0: byte address of register 0; 64-byte aligned.
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port ACLK  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port ARESETN  input  1  asynchronous active-low reset.
REQ-005 SHALL have AR-channel ports: ARADDR in 32; ARVALID in 1; ARREADY out 1; ARID in 12; ARLEN in 4; ARBURST in 2; ARSIZE in 2.
REQ-006 SHALL have R-channel ports: RDATA out 32; RVALID out 1; RREADY in 1; RID out 12; RLAST out 1; RRESP out 2.
REQ-007 SHALL have AW-channel ports: AWADDR in 32; AWVALID in 1; AWREADY out 1; AWID in 12; AWLEN in 4; AWBURST in 2; AWSIZE in 2.
REQ-008 SHALL have W-channel ports: WDATA in 32; WVALID in 1; WREADY out 1; WID in 12; WLAST in 1; WSTRB in 4.
REQ-009 SHALL have B-channel ports: BVALID out 1; BREADY in 1; BID out 12; BRESP out 2.
REQ-010 SHALL accept and ignore the inputs AR/AWLOCK (2), AR/AWCACHE (4), AR/AWPROT (3) and AR/AWQOS (4), as well as WID.
REQ-011 SHALL have port cfg_out  output  32  live value of register 0.
REQ-012 SHALL have port stat_in  input  32  value returned when register 15 is read.

Function
REQ-013 SHALL implement registers 0..14 as 32-bit read/write; register 15 SHALL be read-only, returning stat_in, and writes to it SHALL be dropped with an OKAY response.
REQ-014 SHALL map a beat address A to register index (A-BASE_ADDR)[5:2]; A is in range iff A[31:6]==BASE_ADDR[31:6].
REQ-015 SHALL treat every beat as 32-bit regardless of AR/AWSIZE; address bits [1:0] are ignored.
REQ-016 SHALL advance the address by 4 per beat when BURST is 2'b01 (INCR) or 2'b10 (WRAP treated as INCR), and SHALL keep it constant for 2'b00 (FIXED); the beat count is LEN+1 (1..16).
REQ-017 SHALL run a write FSM with states W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
REQ-018 In W_IDLE, SHALL drive AWREADY=1; on an AW handshake, SHALL latch the address, AWID, length and burst type, then enter W_DATA.
REQ-019 In W_DATA, SHALL drive WREADY=1; on each W handshake, SHALL update the bytes selected by WSTRB in the same edge.
REQ-020 SHALL use the beat count to detect the last beat and ignore WLAST; after the last beat it SHALL enter W_RESP with BVALID=1 on the next cycle.
REQ-021 In W_RESP, SHALL hold BVALID, BID (= latched AWID) and BRESP until BREADY=1, then return to W_IDLE.
REQ-022 SHALL run a read FSM with states R_IDLE -> R_DATA -> R_IDLE, fully independent of the write FSM.
REQ-023 In R_IDLE, SHALL drive ARREADY=1; on an AR handshake, SHALL latch the request and present beat 0 with RVALID=1 on the next cycle.
REQ-024 SHALL hold RDATA, RRESP, RID (= latched ARID) and RLAST stable while RVALID=1 and RREADY=0.
REQ-025 SHALL advance to the next beat on each RVALID&RREADY with no bubble; RLAST=1 only on the final beat; after the final beat it SHALL return to R_IDLE with RVALID=0.
REQ-026 SHALL capture read data when a beat is launched; a write in the same cycle to the same register SHALL NOT be reflected in that beat.
REQ-027 SHALL drive BRESP/RRESP 2'b00 for all in-range beats.

Reset
REQ-028 While ARESETN=0, SHALL force both FSMs to idle and registers 0..14 to 0, and drive AWREADY, WREADY, ARREADY, BVALID, RVALID, RLAST, BRESP, RRESP, BID, RID and RDATA to 0.
REQ-029 A reset asserted mid-burst SHALL abort the burst with no response issued; AW/ARREADY SHALL be 1 on the first edge after release.

Configuration
REQ-030 With AXI_REGS_SLVERR_EN defined, an out-of-range write beat SHALL be dropped, an out-of-range read beat SHALL return 0, and each such beat SHALL give RRESP 2'b10, with BRESP 2'b10 if any beat of the burst was out of range.
REQ-031 Without AXI_REGS_SLVERR_EN, SHALL ignore the upper address bits, index with A[5:2] and always respond 2'b00.

Verification
REQ-032 SHALL verify: after reset, write 32'hdeadbeef to 0x4 with WSTRB 4'b1011, AWID 0 -> BRESP 0, BID 0; read of 0x4 with ARID 12'h5 -> RDATA 32'hde00beef, RID 12'h5, RLAST 1.
REQ-033 SHALL verify: INCR write at 0x8 with AWLEN 3, data 1,2,3,4 and WSTRB 4'hf, then INCR read with ARLEN 3 -> four beats 1,2,3,4, RLAST only on the 4th; cfg_out unchanged (0).
REQ-034 SHALL verify: RREADY held low for 5 cycles during a burst read -> RDATA/RLAST stable and no beat lost; FIXED read of 0x0 with ARLEN 2 -> three identical beats.
REQ-035 SHALL verify: write 32'h1234 to 0x3c with stat_in=32'hcafe -> BRESP 0; read of 0x3c -> 32'hcafe.
REQ-036 SHALL verify: with AXI_REGS_SLVERR_EN, write to 0x40 -> BRESP 2'b10 and register 0 unchanged; read of 0x40 -> RDATA 0, RRESP 2'b10; without the macro, the same write updates register 0.
REQ-037 SHALL verify: ARESETN pulsed low after the 2nd beat of an AWLEN 3 write -> no BVALID, all registers 0, AWREADY 1 after release.
